// File: rtl/sram_like_mem_resp.sv
// sram_like_mem_resp
// ------------------
// Behavioural SRAM-like memory responder with one outstanding transaction.
// A request is accepted combinationally while idle (addr_ok).  The
// transaction completes with a single-cycle data_ok pulse LATENCY+1 cycles
// after acceptance.  Reads return the full stored word on rdata.  Writes
// merge the selected byte lanes into storage at the end of the data_ok cycle.
//
// Parameters
//   ADDR_WIDTH : word-address width; storage is 2**ADDR_WIDTH 32-bit words
//   LATENCY    : base response latency, 0..15
//
// Ports
//   clk     : clock, rising edge
//   rst     : synchronous active-high reset (storage is left untouched)
//   req     : request valid
//   wr      : 1 = write, 0 = read
//   size    : 00 byte, 01 halfword, 10/11 word
//   addr    : byte address; bits [ADDR_WIDTH+1:2] pick the word, upper bits alias
//   wdata   : write data, already placed in its byte lanes
//   rdata   : registered read word, valid while data_ok is high
//   addr_ok : request accepted this cycle
//   data_ok : transaction completes this cycle
//
// Build option
//   MEM_RESP_RAND_LAT_EN : when defined, an 8-bit LFSR adds 0..3 cycles of
//                          latency per request (seed 8'h01, advances on
//                          every accepted request).

module sram_like_mem_resp #(
  parameter int ADDR_WIDTH = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        wr,
  input  logic [1:0]  size,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        addr_ok,
  output logic        data_ok
);

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_e;

  state_e                  state_q, state_d;
  logic [4:0]              cnt_q, cnt_d;
  logic                    wr_q;
  logic [1:0]              size_q;
  logic [1:0]              byteOff_q;
  logic [ADDR_WIDTH-1:0]   wordIdx_q;
  logic [31:0]             wdata_q;
  logic [31:0]             rdata_q;
  logic [31:0]             mem [2**ADDR_WIDTH];

  logic                    accept;
  logic [4:0]              effLat;
  logic [ADDR_WIDTH-1:0]   rdIdx;
  logic                    rdIsWrite;
  logic [3:0]              laneMask;
  logic                    unusedAddrHi;

  // Address bits above the word index simply alias onto the same storage.
  assign unusedAddrHi = ^addr[31:ADDR_WIDTH+2];

`ifdef MEM_RESP_RAND_LAT_EN
  logic [7:0] lfsr_q;

  // Latency jitter source: x^8+x^6+x^5+x^4+1, stepped after its value is used.
  always_ff @(posedge clk) begin
    if (rst) begin
      lfsr_q <= 8'h01;
    end else if (accept) begin
      lfsr_q <= {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
    end
  end

  assign effLat = 5'(LATENCY) + {3'b000, lfsr_q[1:0]};
`else
  assign effLat = 5'(LATENCY);
`endif

  // Acceptance only while idle and never during reset.
  assign accept  = req && (state_q == IDLE) && !rst;
  assign addr_ok = accept;
  assign data_ok = (state_q == RESP) && !rst;
  assign rdata   = rdata_q;

  // With zero latency the read data is fetched on the accepting edge, before
  // the request fields are latched, so the live inputs are used while idle.
  assign rdIdx     = (state_q == IDLE) ? addr[ADDR_WIDTH+1:2] : wordIdx_q;
  assign rdIsWrite = (state_q == IDLE) ? wr : wr_q;

  // Next-state logic: the counter holds the cycles still to wait, and the
  // response cycle follows the cycle in which it reads 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (accept) begin
          cnt_d   = effLat;
          state_d = (effLat == 5'd0) ? RESP : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 5'd1;
        if (cnt_q == 5'd1) begin
          state_d = RESP;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // State, request capture and registered read data.  rdata is loaded on the
  // edge that enters RESP so it is valid exactly in the data_ok cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      cnt_q     <= 5'd0;
      rdata_q   <= 32'h0;
      wr_q      <= 1'b0;
      size_q    <= 2'b00;
      byteOff_q <= 2'b00;
      wordIdx_q <= '0;
      wdata_q   <= 32'h0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        wr_q      <= wr;
        size_q    <= size;
        byteOff_q <= addr[1:0];
        wordIdx_q <= addr[ADDR_WIDTH+1:2];
        wdata_q   <= wdata;
      end
      if ((state_d == RESP) && (state_q != RESP) && !rdIsWrite) begin
        rdata_q <= mem[rdIdx];
      end
    end
  end

  // Byte-lane enables; a misaligned halfword still follows addr[1].
  always_comb begin
    laneMask = 4'b1111;
    case (size_q)
      2'b00:   laneMask = 4'b0001 << byteOff_q;
      2'b01:   laneMask = byteOff_q[1] ? 4'b1100 : 4'b0011;
      default: laneMask = 4'b1111;
    endcase
  end

  // Write commit at the end of the response cycle; a reset drops it.
  always_ff @(posedge clk) begin
    if (!rst && (state_q == RESP) && wr_q) begin
      for (int b = 0; b < 4; b++) begin
        if (laneMask[b]) begin
          mem[wordIdx_q][8*b +: 8] <= wdata_q[8*b +: 8];
        end
      end
    end
  end

endmodule

// File: tb/tb_sram_like_mem_resp.sv
// tb_sram_like_mem_resp
// ---------------------
// Two responders share clock and reset: dutA with LATENCY=2 and dutB with
// LATENCY=0.  A word-level reference memory and latency model predict every
// data_ok timing and every read value.

module tb_sram_like_mem_resp;

  localparam int LAT_A = 2;
  localparam int LAT_B = 0;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        reqA, wrA, aokA, dokA;
  logic [1:0]  sizeA;
  logic [31:0] addrA, wdataA, rdataA;
  logic        reqB, wrB, aokB, dokB;
  logic [1:0]  sizeB;
  logic [31:0] addrB, wdataB, rdataB;

  sram_like_mem_resp #(.ADDR_WIDTH(10), .LATENCY(LAT_A)) dutA (
    .clk(clk), .rst(rst), .req(reqA), .wr(wrA), .size(sizeA), .addr(addrA),
    .wdata(wdataA), .rdata(rdataA), .addr_ok(aokA), .data_ok(dokA));

  sram_like_mem_resp #(.ADDR_WIDTH(10), .LATENCY(LAT_B)) dutB (
    .clk(clk), .rst(rst), .req(reqB), .wr(wrB), .size(sizeB), .addr(addrB),
    .wdata(wdataB), .rdata(rdataB), .addr_ok(aokB), .data_ok(dokB));

  int sel = 0;
  int checks = 0;
  int errors = 0;
  logic [31:0] lastRdata;
  logic [31:0] modelMem [2][1024];
  bit          known    [2][1024];
`ifdef MEM_RESP_RAND_LAT_EN
  logic [7:0]  lfsrModel [2];
`endif

  wire [31:0] rdataS = (sel == 0) ? rdataA : rdataB;
  wire        aokS   = (sel == 0) ? aokA   : aokB;
  wire        dokS   = (sel == 0) ? dokA   : dokB;

  // Single comparison point: counts and reports any mismatch.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic setInputs(input logic r, input logic w, input logic [1:0] s,
                           input logic [31:0] a, input logic [31:0] d);
    if (sel == 0) begin
      reqA = r; wrA = w; sizeA = s; addrA = a; wdataA = d;
    end else begin
      reqB = r; wrB = w; sizeB = s; addrB = a; wdataB = d;
    end
  endtask

  // Expected cycles from acceptance to data_ok, minus one.
  function automatic int modelLatency();
    int lat;
    lat = (sel == 0) ? LAT_A : LAT_B;
`ifdef MEM_RESP_RAND_LAT_EN
    lat += int'(lfsrModel[sel][1:0]);
    lfsrModel[sel] = {lfsrModel[sel][6:0],
                      lfsrModel[sel][7] ^ lfsrModel[sel][5] ^ lfsrModel[sel][4] ^ lfsrModel[sel][3]};
`endif
    return lat;
  endfunction

  function automatic void modelReset();
`ifdef MEM_RESP_RAND_LAT_EN
    lfsrModel[0] = 8'h01;
    lfsrModel[1] = 8'h01;
`endif
  endfunction

  // Reference write merge: pick the first byte and byte count from size/addr.
  function automatic logic [31:0] mergeWrite(input logic [31:0] old, input logic [31:0] d,
                                             input logic [1:0] s, input logic [31:0] a);
    logic [31:0] res;
    int first, n;
    res = old;
    if (s == 2'b00) begin
      first = int'(a[1:0]); n = 1;
    end else if (s == 2'b01) begin
      first = a[1] ? 2 : 0; n = 2;
    end else begin
      first = 0; n = 4;
    end
    for (int i = first; i < first + n; i++) res[8*i +: 8] = d[8*i +: 8];
    return res;
  endfunction

  // One complete transaction on the selected DUT, with random input noise
  // (req held high) while it is in flight.
  task automatic applyStimulus(input string tag, input logic w, input logic [1:0] s,
                               input logic [31:0] a, input logic [31:0] d);
    int lat;
    bit seen;
    int idx;
    idx = int'(a[11:2]);
    @(negedge clk);
    setInputs(1'b1, w, s, a, d);
    #1;
    checkOutput({tag, "_addr_ok"}, 32'(aokS), 32'd1);
    checkOutput({tag, "_idle_data_ok"}, 32'(dokS), 32'd0);
    lat = modelLatency();
    seen = 1'b0;
    for (int k = 1; k <= 25 && !seen; k++) begin
      @(negedge clk);
      setInputs(1'b1, 1'($urandom), 2'($urandom), $urandom, $urandom);
      #1;
      checkOutput({tag, "_busy_addr_ok"}, 32'(aokS), 32'd0);
      if (dokS) begin
        seen = 1'b1;
        checkOutput({tag, "_latency"}, 32'(k), 32'(lat + 1));
        if (!w) begin
          lastRdata = rdataS;
          if (known[sel][idx]) checkOutput({tag, "_rdata"}, rdataS, modelMem[sel][idx]);
        end
      end
    end
    if (!seen) checkOutput({tag, "_timeout"}, 32'd0, 32'd1);
    setInputs(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    if (w) begin
      modelMem[sel][idx] = mergeWrite(modelMem[sel][idx], d, s, a);
      if (s[1]) known[sel][idx] = 1'b1;
    end
  endtask

  initial begin
    reqA = 0; wrA = 0; sizeA = 0; addrA = 0; wdataA = 0;
    reqB = 0; wrB = 0; sizeB = 0; addrB = 0; wdataB = 0;
    lastRdata = 32'h0;
    modelReset();

    // Reset state: addr_ok stays low while rst is high even with req set.
    rst = 1'b1;
    reqA = 1'b1;
    repeat (3) @(negedge clk);
    #1;
    checkOutput("rst_addr_ok", 32'(aokA), 32'd0);
    checkOutput("rst_data_ok", 32'(dokA), 32'd0);
    checkOutput("rst_rdata", rdataA, 32'h0);
    checkOutput("rst_rdataB", rdataB, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    reqA = 1'b0;
    #1;
    checkOutput("post_rst_addr_ok", 32'(aokA), 32'd0);

    $display("[TB] directed sequence on LATENCY=2 instance");
    sel = 0;
    applyStimulus("wr_deadbeef", 1'b1, 2'b10, 32'h10, 32'hDEADBEEF);
    applyStimulus("rd_deadbeef", 1'b0, 2'b10, 32'h10, 32'h0);
    checkOutput("deadbeef_value", lastRdata, 32'hDEADBEEF);

    applyStimulus("wr_11223344", 1'b1, 2'b10, 32'h20, 32'h11223344);
    applyStimulus("wr_byte22", 1'b1, 2'b00, 32'h22, 32'h00AA0000);
    applyStimulus("rd_after_byte", 1'b0, 2'b10, 32'h20, 32'h0);
    checkOutput("byte_merge_value", lastRdata, 32'h11AA3344);
    applyStimulus("wr_half23", 1'b1, 2'b01, 32'h23, 32'h55660000);
    applyStimulus("rd_after_half", 1'b0, 2'b01, 32'h20, 32'h0);
    checkOutput("half_merge_value", lastRdata, 32'h55663344);

    applyStimulus("wr_alias", 1'b1, 2'b11, 32'h0000_0004, 32'h0000_1234);
    applyStimulus("rd_alias", 1'b0, 2'b00, 32'h0000_1004, 32'h0);
    checkOutput("alias_value", lastRdata, 32'h0000_1234);

    // Randomised traffic over a small, fully initialised pool of words.
    for (int i = 0; i < 8; i++)
      applyStimulus("init_poolA", 1'b1, 2'b10, 32'h100 + 32'(4 * i), $urandom);
    for (int n = 0; n < 40; n++)
      applyStimulus("randA", 1'($urandom), 2'($urandom),
                    ($urandom & 32'hFFFF_F000) | (32'h100 + 32'(4 * $urandom_range(0, 7)))
                    | 32'($urandom_range(0, 3)), $urandom);

    // Reset in the middle of a write: no completion and no commit.
    applyStimulus("wr_pre_reset", 1'b1, 2'b10, 32'h40, 32'h0BADF00D);
    @(negedge clk);
    setInputs(1'b1, 1'b1, 2'b10, 32'h40, 32'hFFFFFFFF);
    #1;
    checkOutput("rstwr_addr_ok", 32'(aokA), 32'd1);
    void'(modelLatency());
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkOutput("rstwr_wait_data_ok", 32'(dokA), 32'd0);
    checkOutput("rstwr_rst_addr_ok", 32'(aokA), 32'd0);
    @(negedge clk);
    #1;
    checkOutput("rstwr_after_data_ok", 32'(dokA), 32'd0);
    checkOutput("rstwr_after_rdata", rdataA, 32'h0);
    checkOutput("rstwr_held_addr_ok", 32'(aokA), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    modelReset();
    setInputs(1'b0, 1'b0, 2'b00, 32'h0, 32'h0);
    for (int c = 0; c < 5; c++) begin
      #1;
      checkOutput("rstwr_no_data_ok", 32'(dokA), 32'd0);
      checkOutput("rstwr_out_addr_ok", 32'(aokA), 32'd0);
      @(negedge clk);
    end
    applyStimulus("rd_post_reset", 1'b0, 2'b10, 32'h40, 32'h0);
    checkOutput("reset_no_commit", lastRdata, 32'h0BADF00D);

    $display("[TB] directed sequence on LATENCY=0 instance");
    sel = 1;
    applyStimulus("b_wr80", 1'b1, 2'b10, 32'h80, 32'hCAFE0123);
    applyStimulus("b_rd80", 1'b0, 2'b10, 32'h80, 32'h0);
    applyStimulus("b_next", 1'b0, 2'b10, 32'h80, 32'h0);
    checkOutput("b_value", lastRdata, 32'hCAFE0123);
    for (int i = 0; i < 8; i++)
      applyStimulus("init_poolB", 1'b1, 2'b10, 32'h200 + 32'(4 * i), $urandom);
    for (int n = 0; n < 25; n++)
      applyStimulus("randB", 1'($urandom), 2'($urandom),
                    ($urandom & 32'hFFFF_F000) | (32'h200 + 32'(4 * $urandom_range(0, 7)))
                    | 32'($urandom_range(0, 3)), $urandom);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/sram_like_mem_resp.md
SRAM_LIKE_MEM_RESP -- requirements
Module: sram_like_mem_resp

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, is the word-address width; storage is 2^ADDR_WIDTH 32-bit words.
REQ-002 Parameter LATENCY, default 2, range 0..15, is the cycles between acceptance and data_ok, minus one.
REQ-003 clk  input  1  clock; all state changes on the rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 req  input  1  initiator request valid.
REQ-006 wr  input  1  1 = write, 0 = read.
REQ-007 size  input  2  00 byte, 01 halfword, 10 word, 11 treated as word.
REQ-008 addr  input  32  byte address; bits [ADDR_WIDTH+1:2] select the word, higher bits ignored (aliasing).
REQ-009 wdata  input  32  write data, already positioned in its byte lanes.
REQ-010 rdata  output  32  read word, valid in the data_ok cycle.
REQ-011 addr_ok  output  1  request accepted this cycle.
REQ-012 data_ok  output  1  transaction complete this cycle, one-cycle pulse.

Function
REQ-013 FSM states: IDLE, WAIT, RESP; one outstanding transaction maximum.
REQ-014 In IDLE: addr_ok = req, combinational; all other states: addr_ok = 0.
REQ-015 On req&addr_ok: latch wr, size, addr, wdata; load the latency counter with the effective latency; go to WAIT if latency > 0, else RESP.
REQ-016 WAIT: counter decrements each cycle; moves to RESP on the cycle the counter reaches 1.
REQ-017 RESP: data_ok = 1 for exactly one cycle, then IDLE; request accepted at cycle T gives data_ok at T+1+latency.
REQ-018 No request is accepted in the RESP cycle; earliest next acceptance is the cycle after data_ok.
REQ-019 Read: rdata = stored word at latched word address in the RESP cycle, full 32 bits regardless of size.
REQ-020 rdata is registered and holds its last value outside RESP.
REQ-021 Write: committed to storage at the RESP clock edge; rdata in a write's RESP cycle is don't-care.
REQ-022 Write lane mask: byte -> lane addr[1:0]; halfword -> lanes {1,0} if addr[1]=0, else {3,2}; word/11 -> all lanes.
REQ-023 Only masked lanes update, taking wdata bits from the same lanes; other lanes are unchanged.
REQ-024 Halfword with addr[0]=1 uses the addr[1] rule, with no alignment fault; word size ignores addr[1:0].
REQ-025 Input changes after acceptance have no effect on the transaction in flight.
REQ-026 A read issued after a write's data_ok to the same word returns the written data.

Reset
REQ-027 Reset forces state IDLE, counter 0, addr_ok 0 (combinational via IDLE with req gating still applied after reset), data_ok 0, rdata 32'h0.
REQ-028 Reset mid-transaction drops the transaction: no data_ok and no write commit.
REQ-029 Storage contents are not altered by reset.
REQ-030 While rst is high, addr_ok is forced to 0.

Configuration
REQ-031 Macro MEM_RESP_RAND_LAT_EN controls randomized latency.
REQ-032 With MEM_RESP_RAND_LAT_EN defined: effective latency = LATENCY + lfsr[1:0].
REQ-033 The LFSR is 8 bits, taps x^8+x^6+x^5+x^4+1, reset to 8'h01, advancing once per accepted request after the current value is used.
REQ-034 Without MEM_RESP_RAND_LAT_EN: effective latency = LATENCY, and no LFSR is present.

Verification
REQ-035 LATENCY=2, word write addr 0x10, wdata 0xDEADBEEF, accepted at T -> data_ok at T+3; then a read of 0x10 returns rdata 0xDEADBEEF at its data_ok.
REQ-036 Memory word 0x11223344 at addr 0x20; byte write addr 0x22, wdata 0x00AA0000 -> read of 0x20 gives 0x11AA3344; halfword write addr 0x23, wdata 0x5566_0000 -> read gives 0x55663344.
REQ-037 LATENCY=0, read accepted at T -> data_ok at T+1; addr_ok stays 0 at T+1 even with req held, and is 1 at T+2.
REQ-038 Write accepted, rst asserted in WAIT -> no data_ok, the target word is unchanged, and all outputs are 0 after reset.
REQ-039 ADDR_WIDTH=10, write 0x1234 to addr 0x0000_0004, read addr 0x0000_1004 -> returns 0x1234 (aliasing).
REQ-040 MEM_RESP_RAND_LAT_EN defined, LATENCY=1, eight back-to-back reads -> each data_ok gap is within 2..5 cycles of acceptance and matches the LFSR model from seed 8'h01.
